// File: rtl/rgb_to_gray_stream.sv
// Streaming RGB to grayscale converter, 3-stage global-stall pipeline.
// Per-line mode latch; luma, average, max and green pass-through modes.
module rgb_to_gray_stream #(
  parameter int PIX_W    = 8,
  parameter int COEF_W   = 8,
  parameter int COEF_R   = 77,
  parameter int COEF_G   = 150,
  parameter int COEF_B   = 29,
  parameter int COEF_AVG = 85,
  parameter int ROUND    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PIX_W-1:0] s_r,
  input  logic [PIX_W-1:0] s_g,
  input  logic [PIX_W-1:0] s_b,
  input  logic             s_last,
  input  logic [1:0]       mode,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [PIX_W-1:0] m_gray,
  output logic             m_last
);

  typedef enum logic [1:0] {
    M_LUMA = 2'd0,
    M_AVG  = 2'd1,
    M_MAX  = 2'd2,
    M_PASS = 2'd3
  } mode_e;

  localparam int P = PIX_W + COEF_W;
  localparam int A = P + 2;
  localparam int Q = PIX_W + 2;

  localparam logic [P-1:0] CR = P'(COEF_R);
  localparam logic [P-1:0] CG = P'(COEF_G);
  localparam logic [P-1:0] CB = P'(COEF_B);
  localparam logic [P-1:0] CA = P'(COEF_AVG);
  localparam logic [A-1:0] RND =
    (ROUND != 0) ? (A'(1) << (COEF_W - 1)) : A'(0);
  localparam logic [Q-1:0] QMAX = Q'((1 << PIX_W) - 1);

  logic             en;
  logic             acc_in;
  logic             line_start;
  mode_e            line_mode;
  mode_e            cur_mode;
  logic [PIX_W-1:0] mx;
  logic [P-1:0]     p0_n, p1_n, p2_n;
  logic [P-1:0]     p0, p1, p2;
  logic             v1, l1, v2, l2;
  logic [A-1:0]     acc;
  logic [Q-1:0]     q;
  logic [PIX_W-1:0] sat;

  assign en       = !m_valid || m_ready;
  assign s_ready  = en && !rst;
  assign acc_in   = s_valid && s_ready;
  assign cur_mode = line_start ? mode_e'(mode) : line_mode;

  always_comb begin
    mx = s_r;
    if (s_g > mx) mx = s_g;
    if (s_b > mx) mx = s_b;
  end

  // Average mode splits the weight per channel so each product fits P bits
  always_comb begin
    p0_n = '0;
    p1_n = '0;
    p2_n = '0;
    unique case (cur_mode)
      M_LUMA: begin
        p0_n = P'(s_r) * CR;
        p1_n = P'(s_g) * CG;
        p2_n = P'(s_b) * CB;
      end
      M_AVG: begin
        p0_n = P'(s_r) * CA;
        p1_n = P'(s_g) * CA;
        p2_n = P'(s_b) * CA;
      end
      M_MAX:  p0_n = {mx, {COEF_W{1'b0}}};
      M_PASS: p0_n = {s_g, {COEF_W{1'b0}}};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_start <= 1'b1;
      line_mode  <= M_LUMA;
    end else if (acc_in) begin
      if (line_start) line_mode <= mode_e'(mode);
      line_start <= s_last;
    end
  end

  assign q   = acc[A-1:COEF_W];
  assign sat = (q > QMAX) ? {PIX_W{1'b1}} : q[PIX_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1      <= 1'b0;
      l1      <= 1'b0;
      p0      <= '0;
      p1      <= '0;
      p2      <= '0;
      v2      <= 1'b0;
      l2      <= 1'b0;
      acc     <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_gray  <= '0;
    end else if (en) begin
      v1      <= acc_in;
      l1      <= acc_in && s_last;
      p0      <= p0_n;
      p1      <= p1_n;
      p2      <= p2_n;
      v2      <= v1;
      l2      <= l1;
      acc     <= A'(p0) + A'(p1) + A'(p2) + RND;
      m_valid <= v2;
      m_last  <= l2;
      m_gray  <= sat;
    end
  end

endmodule

// File: tb/tb_rgb_to_gray_stream.sv
// Scoreboard bench for rgb_to_gray_stream.
// Extra instances cover saturation and truncation parameters.
module tb_rgb_to_gray_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid;
  logic [7:0] s_r, s_g, s_b;
  logic       s_last;
  logic [1:0] mode;
  logic       m_ready;

  logic       s_ready, m_valid, m_last;
  logic [7:0] m_gray;
  logic       s_ready_s, m_valid_s, m_last_s;
  logic [7:0] m_gray_s;
  logic       s_ready_t, m_valid_t, m_last_t;
  logic [7:0] m_gray_t;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int gray;
    bit last;
  } exp_t;

  exp_t sbq[$];
  bit   ls_m = 1'b1;
  int   lmode_m = 0;

  always #5 clk = ~clk;

  rgb_to_gray_stream dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_r(s_r), .s_g(s_g), .s_b(s_b),
    .s_last(s_last), .mode(mode),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_gray(m_gray), .m_last(m_last)
  );

  rgb_to_gray_stream #(
    .COEF_R(255), .COEF_G(255), .COEF_B(255)
  ) u_sat (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready_s),
    .s_r(s_r), .s_g(s_g), .s_b(s_b),
    .s_last(s_last), .mode(mode),
    .m_valid(m_valid_s), .m_ready(m_ready),
    .m_gray(m_gray_s), .m_last(m_last_s)
  );

  rgb_to_gray_stream #(
    .ROUND(0)
  ) u_trn (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready_t),
    .s_r(s_r), .s_g(s_g), .s_b(s_b),
    .s_last(s_last), .mode(mode),
    .m_valid(m_valid_t), .m_ready(m_ready),
    .m_gray(m_gray_t), .m_last(m_last_t)
  );

  function automatic int model(int md, int r, int g, int b);
    int a;
    int mx;
    case (md)
      0: a = r * 77 + g * 150 + b * 29;
      1: a = (r + g + b) * 85;
      2: begin
        mx = r;
        if (g > mx) mx = g;
        if (b > mx) mx = b;
        a = mx * 256;
      end
      default: a = g * 256;
    endcase
    a = (a + 128) >> 8;
    if (a > 255) a = 255;
    return a;
  endfunction

  function automatic void accept_model(int r, int g, int b,
                                       bit last, int md_in);
    int   md;
    exp_t e;
    md = ls_m ? md_in : lmode_m;
    if (ls_m) lmode_m = md_in;
    ls_m   = last;
    e.gray = model(md, r, g, b);
    e.last = last;
    sbq.push_back(e);
  endfunction

  task automatic send(int r, int g, int b, bit last, int md);
    int n;
    bit ok;
    s_valid = 1'b1;
    s_r     = 8'(r);
    s_g     = 8'(g);
    s_b     = 8'(b);
    s_last  = last;
    mode    = 2'(md);
    n       = 0;
    ok      = 1'b0;
    forever begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
      n++;
      if (n > 200) break;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout s_ready=%b required=1", s_ready);
    end else begin
      accept_model(r, g, b, last, md);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() > 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", sbq.size());
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (m_valid && m_ready) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected gray=%0d last=%b required=none",
                   m_gray, m_last);
        end else begin
          e = sbq.pop_front();
          if (m_gray !== 8'(e.gray) || m_last !== e.last) begin
            errors++;
            $display("FAIL out_data gray=%0d last=%b required=%0d/%b",
                     m_gray, m_last, e.gray, e.last);
          end
        end
      end else if (m_valid && !m_ready) begin
        checks++;
        if (s_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall_ready s_ready=%b required=0", s_ready);
        end
        if (sbq.size() > 0) begin
          checks++;
          if (m_gray !== 8'(sbq[0].gray) || m_last !== sbq[0].last) begin
            errors++;
            $display("FAIL stall_hold gray=%0d required=%0d",
                     m_gray, sbq[0].gray);
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst     = 1'b1;
    s_valid = 1'b0;
    s_r     = '0;
    s_g     = '0;
    s_b     = '0;
    s_last  = 1'b0;
    mode    = '0;
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (m_valid !== 1'b0 || m_gray !== 8'd0 || m_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_out v=%b g=%0d l=%b required=0/0/0",
               m_valid, m_gray, m_last);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready s_ready=%b required=1", s_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_latency();
    int n;
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_r     = 8'd255;
    s_g     = 8'd255;
    s_b     = 8'd255;
    s_last  = 1'b1;
    mode    = 2'd0;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL lat_ready s_ready=%b required=1", s_ready);
    end
    accept_model(255, 255, 255, 1'b1, 0);
    n = 0;
    forever begin
      @(posedge clk);
      n++;
      #1;
      s_valid = 1'b0;
      if (m_valid || n >= 10) break;
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL latency cycles=%0d required=3", n);
    end
    drain();
  endtask

  task automatic test_modes();
    m_ready = 1'b1;
    send(255, 0, 0, 1'b1, 0);
    send(30, 60, 90, 1'b1, 1);
    send(10, 200, 50, 1'b1, 2);
    send(7, 123, 9, 1'b1, 3);
    drain();
  endtask

  task automatic test_back_to_back();
    m_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 16; i++)
          send(i * 10, i * 15, i * 5, i == 15, 0);
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        m_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        m_ready = 1'b1;
      end
    join
    drain();
  endtask

  task automatic test_mode_latch();
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++)
      send(20 + i, 100 + i * 10, 40, i == 7, (i < 3) ? 0 : 2);
    send(30, 90, 60, 1'b1, 2);
    drain();
  endtask

  task automatic test_params();
    m_ready = 1'b1;
    send(255, 255, 255, 1'b1, 0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (m_valid_s !== 1'b1 || m_gray_s !== 8'd255) begin
      errors++;
      $display("FAIL sat_white v=%b g=%0d required=1/255",
               m_valid_s, m_gray_s);
    end
    send(255, 0, 0, 1'b1, 0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (m_valid_t !== 1'b1 || m_gray_t !== 8'd76) begin
      errors++;
      $display("FAIL trunc_red v=%b g=%0d required=1/76",
               m_valid_t, m_gray_t);
    end
    checks++;
    if (m_gray_s !== 8'd254) begin
      errors++;
      $display("FAIL sat_red g=%0d required=254", m_gray_s);
    end
    drain();
  endtask

  task automatic test_async_reset();
    m_ready = 1'b1;
    send(1, 2, 3, 1'b0, 3);
    send(4, 5, 6, 1'b0, 3);
    send(7, 8, 9, 1'b0, 3);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_rst m_valid=%b required=0", m_valid);
    end
    sbq.delete();
    ls_m    = 1'b1;
    lmode_m = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    send(10, 200, 50, 1'b1, 1);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_latency();
    test_modes();
    test_back_to_back();
    test_mode_latch();
    test_params();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
